// File: rtl/wfifo_write_front.sv
// Write-side front end of the async FIFO: two-entry skid buffer feeding the
// FIFO write port, plus registered fill level / almost-full decode.
module wfifo_write_front #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 s_ready,
  output logic                 winc,
  output logic [DATA_SIZE-1:0] wdata,
  input  logic                 wfull,
  input  logic [ADDR_SIZE:0]   wptr,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 walmost_full
);

  localparam int unsigned PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [DATA_SIZE-1:0] skid;
  logic                 accept;
  logic                 fire;
  logic [PW-1:0]        wbin;
  logic [PW-1:0]        rbin;
  logic [PW-1:0]        level;

  // wfull is already registered upstream, so gating the strobe with it is glitch-safe
  assign accept = s_valid & s_ready;
  assign fire   = (state != EMPTY) & ~wfull;
  assign winc   = fire;

  // Next occupancy of the skid buffer
  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (accept) state_n = ONE;
      ONE: begin
        if (accept && !fire)      state_n = TWO;
        else if (!accept && fire) state_n = EMPTY;
      end
      TWO:     if (fire) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state   <= EMPTY;
      wdata   <= '0;
      skid    <= '0;
      s_ready <= 1'b0;
    end else begin
      state   <= state_n;
      s_ready <= (state_n != TWO);
      case (state)
        EMPTY: if (accept) wdata <= s_data;
        ONE: begin
          if (accept && fire) wdata <= s_data;
          else if (accept)    skid  <= s_data;
        end
        TWO:     if (fire) wdata <= skid;
        default: ;
      endcase
    end
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // Modular subtraction absorbs pointer wrap-around
  assign wbin  = gray2bin(wptr);
  assign rbin  = gray2bin(wq2_rptr);
  assign level = wbin - rbin;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level;
      walmost_full <= (level >= THRESH);
    end
  end

endmodule

// File: tb/tb_wfifo_write_front.sv
// Randomised bench for wfifo_write_front: word-order scoreboard plus an
// occupancy/pointer-arithmetic reference model checked every falling edge.
module tb_wfifo_write_front;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned PW    = AW + 1;
  localparam int          DEPTH = 1 << AW;
  localparam int          TH    = 12;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull = 1'b0;
  logic [PW-1:0] wptr = '0;
  logic [PW-1:0] wq2_rptr = '0;
  logic [PW-1:0] wlevel;
  logic          walmost_full;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] expq[$];
  int            occ = 0;
  bit            armed = 0;
  bit            lvl_valid = 0;
  int            lvl_exp = 0;
  bit            exp_rdy;
  bit            exp_fire;
  logic [DW-1:0] word;

  wfifo_write_front #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_THRESH(TH)) dut (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
    .wptr(wptr), .wq2_rptr(wq2_rptr), .wlevel(wlevel), .walmost_full(walmost_full)
  );

  initial forever #5 wclk = ~wclk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: find the binary count whose Gray image matches
  function automatic int g2b(input logic [PW-1:0] g);
    for (int b = 0; b < 2 * DEPTH; b++)
      if (PW'(b ^ (b >> 1)) == g) return b;
    return 0;
  endfunction

  function automatic logic [PW-1:0] b2g(input int b);
    return PW'(b ^ (b >> 1));
  endfunction

  function automatic int level_of(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return ((g2b(w) - g2b(r)) % (2 * DEPTH) + 2 * DEPTH) % (2 * DEPTH);
  endfunction

  // The handshake can open only after a clock edge seen out of reset
  always @(posedge wclk or posedge wrst) armed = !wrst;

  // Monitor: occupancy model predicts s_ready/winc, queue predicts wdata
  always @(negedge wclk or posedge wrst) begin
    if (wrst) begin
      occ = 0;
      expq.delete();
      lvl_valid = 0;
    end else begin
      exp_rdy  = armed && (occ < 2);
      exp_fire = (occ > 0) && !wfull;
      check("s_ready", int'(s_ready), int'(exp_rdy));
      check("winc", int'(winc), int'(exp_fire));
      if (exp_fire) begin
        word = expq.pop_front();
        check("wdata", int'(wdata), int'(word));
      end
      if (lvl_valid) begin
        check("wlevel", int'(wlevel), lvl_exp);
        check("walmost_full", int'(walmost_full), int'(lvl_exp >= TH));
      end
      lvl_exp   = level_of(wptr, wq2_rptr);
      lvl_valid = 1;
      if (s_valid && exp_rdy) begin
        expq.push_back(s_data);
        occ++;
      end
      if (exp_fire) occ--;
    end
  end

  task automatic send(input logic [DW-1:0] d);
    bit ok;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge wclk);
      ok = s_ready;
      @(posedge wclk);
      #1;
      if (ok) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: word %0h never accepted", d);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic set_ptrs(input logic [PW-1:0] w, input logic [PW-1:0] r);
    wptr     = w;
    wq2_rptr = r;
    idle(2);
  endtask

  initial begin
    int rb;
    int lv;
    // Reset held with a valid word offered and nonzero pointers
    s_valid = 1'b1;
    s_data  = 8'h77;
    wptr    = 5'b01101;
    repeat (3) begin
      @(negedge wclk);
      check("rst_s_ready", int'(s_ready), 0);
      check("rst_winc", int'(winc), 0);
      check("rst_wdata", int'(wdata), 0);
      check("rst_wlevel", int'(wlevel), 0);
      check("rst_afull", int'(walmost_full), 0);
    end
    @(posedge wclk);
    #1;
    wrst    = 1'b0;
    s_valid = 1'b0;
    idle(3);

    // Back-to-back stream
    for (int i = 1; i <= 5; i++) send(DW'(i));
    idle(4);

    // Backpressure: fill both entries while full
    wfull = 1'b1;
    send(8'hA1);
    send(8'hA2);
    idle(3);
    wfull = 1'b0;
    idle(4);

    // Level decode, wrap and full cases
    set_ptrs(5'b01101, 5'b00000);
    set_ptrs(5'b11001, 5'b00010);
    set_ptrs(5'b00011, 5'b10001);
    set_ptrs(5'b11000, 5'b00000);
    set_ptrs(b2g(TH), b2g(0));
    set_ptrs(b2g(TH - 1), b2g(0));

    // Random traffic, full flag and pointers
    for (int i = 0; i < 400; i++) begin
      s_valid  = 1'($urandom_range(0, 1));
      s_data   = DW'($urandom);
      wfull    = ($urandom_range(0, 3) == 0);
      rb       = int'($urandom_range(0, 2 * DEPTH - 1));
      lv       = int'($urandom_range(0, DEPTH));
      wptr     = b2g((rb + lv) % (2 * DEPTH));
      wq2_rptr = b2g(rb);
      @(posedge wclk);
      #1;
    end
    s_valid = 1'b0;
    wfull   = 1'b0;
    idle(4);

    // Asynchronous reset between edges while holding two words
    wfull = 1'b1;
    send(8'hB1);
    send(8'hB2);
    idle(2);
    @(posedge wclk);
    #2;
    wrst = 1'b1;
    #1;
    check("async_winc", int'(winc), 0);
    check("async_s_ready", int'(s_ready), 0);
    check("async_wdata", int'(wdata), 0);
    check("async_wlevel", int'(wlevel), 0);
    #1;
    wrst  = 1'b0;
    wfull = 1'b0;
    idle(2);
    send(8'h5C);
    idle(6);

    check("drain_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
